ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain controller for one FPGA tile that has two independent ccff chains: chain 0 (connection-box chain) and chain 1 (switch-box chain).
- Accepts a packed bitstream as words over a valid/ready interface and serialises it onto ccff_head_0, then ccff_head_1.
- Generates a per-chain shift enable for the chain clock gates, and holds the fabric isolated (isol_n low) until both chains are loaded and settled.
- Sits between the bitstream source and the tile's ccff_head/ccff_head_1 inputs.

Parameters:
- WORD_W, 8, bitstream word width.
- CHAIN0_LEN, 64, bits in chain 0 (cbx).
- CHAIN1_LEN, 48, bits in chain 1 (sb).
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > max(CHAIN0_LEN, CHAIN1_LEN).
- ISOL_HOLD, 2, settle cycles after the last shift before isol_n is released.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  pulse; begins a load when in IDLE or DONE.
- abort  in  1  pulse; cancels a load in progress.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid & cfg_ready.
- ccff_head_0  out  1  serial data to chain 0.
- ccff_head_1  out  1  serial data to chain 1.
- ccff_shift_en  out  2  per-chain shift enable; bit i gates chain i.
- isol_n  out  1  0 = fabric isolated.
- busy  out  1  load in progress.
- done  out  1  both chains loaded and settled.

Behaviour:
- Reset values:
  - All outputs 0: isol_n=0, done=0, busy=0, cfg_ready=0, ccff_shift_en=0, heads=0.
  - State IDLE, bit counter 0, shifter empty.
- States: IDLE, LOAD0, LOAD1, SETTLE, DONE.
- IDLE:
  - start -> LOAD0, busy=1, isol_n=0, done=0.
- Bitstream packing:
  - Contiguous across chains. Chain 0 takes the first CHAIN0_LEN bits, chain 1 the next CHAIN1_LEN.
  - A word may straddle the chain boundary.
  - Bits beyond CHAIN0_LEN+CHAIN1_LEN in the last word are discarded.
- Shifter:
  - Holds one word and a remaining-bit count.
  - cfg_ready=1 in LOAD0/LOAD1 when the shifter is empty, or when it holds exactly 1 remaining bit and that bit is shifted this cycle. This gives bubble-free streaming under continuous cfg_valid.
  - cfg_ready=0 in all other states.
- Serial output timing:
  - A bit is presented on ccff_head_i and ccff_shift_en[i]=1 in the same cycle, registered.
  - The first bit appears the cycle after the first word is accepted.
- Stall:
  - If the shifter is empty and cfg_valid=0, ccff_shift_en=0 and the heads hold their value.
  - The counter does not advance. No error is raised.
- LOAD0:
  - After the CHAIN0_LEN-th shift, go to LOAD1 and clear the counter.
  - The next bit goes to chain 1 on the following cycle with no bubble if data is available.
- LOAD1:
  - After the CHAIN1_LEN-th shift, go to SETTLE.
  - Drop the shifter remainder and drive cfg_ready=0.
- ccff_shift_en:
  - Never has both bits 1 in the same cycle.
  - Bit 1 is never 1 in LOAD0; bit 0 is never 1 in LOAD1.
- SETTLE:
  - Count ISOL_HOLD cycles with shift_en=0, then go to DONE.
- DONE:
  - done=1, isol_n=1, busy=0.
  - start -> LOAD0, with done=0 and isol_n=0 on the next cycle.
- start while busy: ignored.
- abort:
  - In LOAD0/LOAD1/SETTLE: go to IDLE next cycle.
  - Shifter flushed, shift_en=0, isol_n=0, done=0, busy=0.
  - In IDLE/DONE: no effect.
- Priority: prog_reset > abort > start.
- Reset mid-load: same values as power-on reset. Chain contents are undefined and must be reloaded.
- Zero-length chain (CHAINx_LEN=0): that LOAD state is skipped (elaboration-time decision).

Decomposition:
- Package ccff_chain_loader_pkg:
  - State enum (IDLE, LOAD0, LOAD1, SETTLE, DONE).
  - Default WORD_W and CNT_W constants.
  - Function computing the word count for a given total bit count.
- One sub-module, ccff_word_shifter:
  - Ports: load, word, shift, bit_out, empty, last.
  - Owns the word register and remaining-bit count.
  - The FSM and counters stay in the top module.

Test Plan:
- Defaults, continuous valid, 14 words (0xA5, 0x3C, ...):
  - shift_en[0] high for exactly 64 consecutive cycles, then shift_en[1] for exactly 48.
  - Chain model contents match the bitstream MSB-first.
  - isol_n rises 2 cycles after the last shift, together with done.
- CHAIN0_LEN=12, CHAIN1_LEN=10, words 0xFF, 0x0F, 0xC3:
  - Word 2 straddles the boundary.
  - Chain 0 gets 12 bits, chain 1 gets 10.
  - The last 2 bits of 0xC3 are discarded; cfg_ready=0 after word 3.
- cfg_valid dropped for 5 cycles mid-LOAD0:
  - shift_en=0 for exactly those cycles; counter frozen.
  - Final chain contents unchanged versus the no-stall run.
- abort pulse at bit 30 of LOAD0:
  - IDLE next cycle, busy=0, isol_n=0, cfg_ready=0.
  - A new start reloads the full 112 bits correctly.
- prog_reset=0 asserted during LOAD1, then start:
  - All outputs at reset values the cycle after reset; full reload succeeds.
- start pulsed during LOAD1:
  - Ignored; total shift count stays 112.
  - start in DONE restarts the load, with done falling next cycle.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the ccff chain loader.
//   state_e         : loader FSM states
//   DEF_WORD_W      : default bitstream word width
//   DEF_CNT_W       : default bit-counter width
//   words_for_bits  : number of words needed to carry a given bit count
package ccff_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD0  = 3'd1,
    ST_LOAD1  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned DEF_WORD_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  function automatic int unsigned words_for_bits(input int unsigned bits,
                                                 input int unsigned word_w);
    return (word_w == 0) ? 0 : (bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// One-word parallel-to-serial shifter, MSB first.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : discard any remaining bits
//   load_i        : capture word_i
//   word_i        : incoming word
//   shift_i       : consume one bit this cycle
//   bit_o         : bit consumed by a shift this cycle
//   empty_o       : no bits remaining
//   last_o        : exactly one bit remaining
module ccff_word_shifter
  import ccff_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              shift_i,
  output logic              bit_o,
  output logic              empty_o,
  output logic              last_o
);

  localparam int unsigned REM_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [REM_W-1:0]  rem_q, rem_d;

  assign empty_o = (rem_q == '0);
  assign last_o  = (rem_q == REM_W'(1));

  // When empty, a word loaded this cycle supplies its MSB directly so the
  // first bit leaves on the same edge the word is accepted.
  assign bit_o = empty_o ? word_i[WORD_W-1] : word_q[WORD_W-1];

  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    if (flush_i) begin
      rem_d = '0;
    end else if (load_i) begin
      if (shift_i && empty_o) begin
        word_d = word_i << 1;
        rem_d  = REM_W'(WORD_W - 1);
      end else begin
        word_d = word_i;
        rem_d  = REM_W'(WORD_W);
      end
    end else if (shift_i && !empty_o) begin
      word_d = word_q << 1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      rem_q  <= '0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller for a tile with two ccff chains.
// Streams a packed bitstream (chain 0 bits, then chain 1 bits) onto the
// chain heads with per-chain shift enables, and keeps the fabric isolated
// until both chains are loaded and have settled.
//   prog_clk      : configuration clock
//   prog_reset    : synchronous active-low reset
//   start, abort  : begin / cancel a load (pulses)
//   cfg_data      : bitstream word, MSB shifted first
//   cfg_valid     : cfg_data valid
//   cfg_ready     : word accepted when cfg_valid & cfg_ready
//   ccff_head_0/1 : serial data to chain 0 / chain 1
//   ccff_shift_en : bit i gates chain i
//   isol_n        : 0 = fabric isolated
//   busy, done    : load in progress / both chains loaded and settled
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned CHAIN0_LEN = 64,
  parameter int unsigned CHAIN1_LEN = 48,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned ISOL_HOLD  = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head_0,
  output logic              ccff_head_1,
  output logic [1:0]        ccff_shift_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SET_W = (ISOL_HOLD > 1) ? $clog2(ISOL_HOLD) : 1;

  localparam logic [CNT_W-1:0] LAST0_C =
    CNT_W'((CHAIN0_LEN > 0) ? CHAIN0_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] LAST1_C =
    CNT_W'((CHAIN1_LEN > 0) ? CHAIN1_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] TOTAL_WORDS_C =
    CNT_W'(words_for_bits(CHAIN0_LEN + CHAIN1_LEN, WORD_W));
  localparam logic [SET_W-1:0] SET_LAST_C =
    SET_W'((ISOL_HOLD > 0) ? ISOL_HOLD - 1 : 0);

  // Zero-length chains and a zero settle time skip their states entirely.
  localparam state_e AFTER1_ST = (ISOL_HOLD != 0) ? ST_SETTLE : ST_DONE;
  localparam state_e AFTER0_ST = (CHAIN1_LEN != 0) ? ST_LOAD1 : AFTER1_ST;
  localparam state_e FIRST_ST  = (CHAIN0_LEN != 0) ? ST_LOAD0 : AFTER0_ST;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               head0_q, head0_d;
  logic               head1_q, head1_d;
  logic [1:0]         en_q, en_d;

  logic in_load;
  logic accept;
  logic shift;
  logic end0;
  logic end1;
  logic flush;
  logic sh_bit;
  logic sh_empty;
  logic sh_last;

  assign in_load = (state_q == ST_LOAD0) || (state_q == ST_LOAD1);
  assign accept  = cfg_valid && cfg_ready;
  assign shift   = in_load && !abort && (!sh_empty || accept);
  assign end0    = (state_q == ST_LOAD0) && shift && (cnt_q == LAST0_C);
  assign end1    = (state_q == ST_LOAD1) && shift && (cnt_q == LAST1_C);
  // Leaving the load states for any reason drops whatever is left.
  assign flush   = !((state_d == ST_LOAD0) || (state_d == ST_LOAD1));

  ccff_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk_i   (prog_clk),
    .rst_ni  (prog_reset),
    .flush_i (flush),
    .load_i  (accept),
    .word_i  (cfg_data),
    .shift_i (shift),
    .bit_o   (sh_bit),
    .empty_o (sh_empty),
    .last_o  (sh_last)
  );

  // State register
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = FIRST_ST;
      ST_LOAD0: begin
        if (abort)     state_d = ST_IDLE;
        else if (end0) state_d = AFTER0_ST;
      end
      ST_LOAD1: begin
        if (abort)     state_d = ST_IDLE;
        else if (end1) state_d = AFTER1_ST;
      end
      ST_SETTLE: begin
        if (abort)                        state_d = ST_IDLE;
        else if (settle_q == SET_LAST_C)  state_d = ST_DONE;
      end
      ST_DONE:   if (start) state_d = FIRST_ST;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    isol_n    = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      ST_LOAD0, ST_LOAD1: begin
        busy = 1'b1;
        // The word counter stops the final shift of an exactly-filled
        // last word from pulling in a word beyond the bitstream.
        cfg_ready = !abort && (words_q < TOTAL_WORDS_C) && (sh_empty || sh_last);
      end
      ST_SETTLE: busy = 1'b1;
      ST_DONE: begin
        done   = 1'b1;
        isol_n = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: bit/word/settle counters and registered heads
  always_comb begin
    cnt_d    = cnt_q;
    words_d  = words_q;
    settle_d = settle_q;
    head0_d  = head0_q;
    head1_d  = head1_q;
    en_d     = '0;
    if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
      cnt_d    = '0;
      words_d  = '0;
      settle_d = '0;
    end
    if (accept) begin
      words_d = words_q + 1'b1;
    end
    if (shift) begin
      if (state_q == ST_LOAD0) begin
        head0_d = sh_bit;
        en_d    = 2'b01;
        cnt_d   = end0 ? '0 : cnt_q + 1'b1;
      end else begin
        head1_d = sh_bit;
        en_d    = 2'b10;
        cnt_d   = end1 ? '0 : cnt_q + 1'b1;
      end
    end
    if (state_q == ST_SETTLE) begin
      settle_d = settle_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      cnt_q    <= '0;
      words_q  <= '0;
      settle_q <= '0;
      head0_q  <= 1'b0;
      head1_q  <= 1'b0;
      en_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      settle_q <= settle_d;
      head0_q  <= head0_d;
      head1_q  <= head1_d;
      en_q     <= en_d;
    end
  end

  assign ccff_head_0   = head0_q;
  assign ccff_head_1   = head1_q;
  assign ccff_shift_en = en_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: default geometry 64 + 48 ----------------
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, h0, h1, isol_n, busy, done;
  logic [1:0] en;

  ccff_chain_loader #(
    .WORD_W(8), .CHAIN0_LEN(64), .CHAIN1_LEN(48), .CNT_W(16), .ISOL_HOLD(2)
  ) dut (
    .prog_clk(clk), .prog_reset(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head_0(h0), .ccff_head_1(h1), .ccff_shift_en(en),
    .isol_n(isol_n), .busy(busy), .done(done)
  );

  // ---------------- DUT B: straddle geometry 12 + 10 ----------------
  logic       b_start = 1'b0;
  logic       b_abort = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_h0, b_h1, b_isol, b_busy, b_done;
  logic [1:0] b_en;

  ccff_chain_loader #(
    .WORD_W(8), .CHAIN0_LEN(12), .CHAIN1_LEN(10), .CNT_W(16), .ISOL_HOLD(2)
  ) dut_b (
    .prog_clk(clk), .prog_reset(rst_n), .start(b_start), .abort(b_abort),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .ccff_head_0(b_h0), .ccff_head_1(b_h1), .ccff_shift_en(b_en),
    .isol_n(b_isol), .busy(b_busy), .done(b_done)
  );

  // Bitstream for DUT A: 14 words plus one spare that must never be taken.
  logic [7:0] words_a [15] = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hF0, 8'h5A, 8'hC3,
                               8'hE1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                               8'h55};
  logic [7:0] words_b [4]  = '{8'hFF, 8'h0F, 8'hC3, 8'h55};

  function automatic logic exp_bit(input int n);
    logic [7:0] w;
    w = words_a[n / 8];
    return w[7 - (n % 8)];
  endfunction

  // ---------------- feeders: valid decided at negedge+1, handshake seen at +3
  int feed_idx = 0, accepted = 0, stall_word = -1, stall_left = 0;
  bit feed_on = 1'b0;
  always @(negedge clk) begin
    #1;
    if (feed_on && feed_idx < 15) begin
      if (feed_idx == stall_word && stall_left > 0 && cfg_ready) begin
        cfg_valid = 1'b0;
        stall_left--;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = words_a[feed_idx];
      end
    end else begin
      cfg_valid = 1'b0;
    end
    #2;
    if (cfg_valid && cfg_ready) begin
      feed_idx++;
      accepted++;
    end
  end

  int b_idx = 0, b_accepted = 0;
  bit b_feed_on = 1'b0;
  always @(negedge clk) begin
    #1;
    if (b_feed_on && b_idx < 4) begin
      b_valid = 1'b1;
      b_data  = words_b[b_idx];
    end else begin
      b_valid = 1'b0;
    end
    #2;
    if (b_valid && b_ready) begin
      b_idx++;
      b_accepted++;
    end
  end

  // ---------------- monitors (sample at negedge) ----------------
  int cyc = 0;
  int en0_cnt, en1_cnt, en0_first, en0_last, en1_first, en1_last;
  int both_hi, isol_rise, done_rise;
  logic bits0 [128];
  logic bits1 [128];
  always @(negedge clk) begin
    cyc++;
    if (en[0] === 1'b1) begin
      if (en0_cnt < 128) bits0[en0_cnt] = h0;
      if (en0_first < 0) en0_first = cyc;
      en0_last = cyc;
      en0_cnt++;
    end
    if (en[1] === 1'b1) begin
      if (en1_cnt < 128) bits1[en1_cnt] = h1;
      if (en1_first < 0) en1_first = cyc;
      en1_last = cyc;
      en1_cnt++;
    end
    if (en === 2'b11) both_hi++;
    if (isol_n === 1'b1 && isol_rise < 0) isol_rise = cyc;
    if (done === 1'b1 && done_rise < 0) done_rise = cyc;
  end

  int b_en0_cnt = 0, b_en1_cnt = 0, b_both = 0, b_ready_after = 0;
  logic [11:0] m0 = '0;
  logic [9:0]  m1 = '0;
  always @(negedge clk) begin
    if (b_en[0] === 1'b1) begin m0 = {m0[10:0], b_h0}; b_en0_cnt++; end
    if (b_en[1] === 1'b1) begin m1 = {m1[8:0], b_h1}; b_en1_cnt++; end
    if (b_en === 2'b11) b_both++;
    if (b_accepted >= 3 && b_ready === 1'b1) b_ready_after++;
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  task automatic clear_mon;
    en0_cnt = 0; en1_cnt = 0;
    en0_first = -1; en0_last = -1; en1_first = -1; en1_last = -1;
    both_hi = 0; isol_rise = -1; done_rise = -1;
  endtask

  task automatic begin_load(input int s_word, input int s_cycles);
    clear_mon();
    feed_idx = 0; accepted = 0;
    stall_word = s_word; stall_left = s_cycles;
    feed_on = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) tick();
    feed_on = 1'b0;
  endtask

  function automatic int content_errs();
    int m;
    m = 0;
    for (int i = 0; i < 64; i++) if (bits0[i] !== exp_bit(i)) m++;
    for (int i = 0; i < 48; i++) if (bits1[i] !== exp_bit(64 + i)) m++;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", cfg_ready); end
    checks++; if (h0 !== 1'b0 || h1 !== 1'b0) begin errors++; $display("FAIL rst_heads got %b%b want 00", h1, h0); end
    checks++; if (en !== 2'b00) begin errors++; $display("FAIL rst_shift_en got %b want 00", en); end
    checks++; if (isol_n !== 1'b0) begin errors++; $display("FAIL rst_isol_n got %b want 0", isol_n); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    checks++; if (b_ready !== 1'b0 || b_en !== 2'b00 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_b got r%b en%b busy%b want 0 00 0", b_ready, b_en, b_busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || isol_n !== 1'b0) begin errors++; $display("FAIL idle_after_rst busy=%b isol=%b want 0 0", busy, isol_n); end
  endtask

  task automatic test_continuous;
    bit to;
    int m;
    begin_load(-1, 0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL cont_timeout done never rose"); end
    checks++; if (en0_cnt !== 64) begin errors++; $display("FAIL cont_en0_count got %0d want 64", en0_cnt); end
    checks++; if (en0_last - en0_first + 1 !== 64) begin errors++; $display("FAIL cont_en0_span got %0d want 64", en0_last - en0_first + 1); end
    checks++; if (en1_cnt !== 48) begin errors++; $display("FAIL cont_en1_count got %0d want 48", en1_cnt); end
    checks++; if (en1_first !== en0_last + 1) begin errors++; $display("FAIL cont_boundary en1_first=%0d want %0d", en1_first, en0_last + 1); end
    checks++; if (en1_last - en1_first + 1 !== 48) begin errors++; $display("FAIL cont_en1_span got %0d want 48", en1_last - en1_first + 1); end
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL cont_both_en got %0d want 0", both_hi); end
    m = content_errs();
    checks++; if (m !== 0) begin errors++; $display("FAIL cont_contents wrong_bits=%0d want 0", m); end
    checks++; if (isol_rise !== en1_last + 2) begin errors++; $display("FAIL cont_isol_timing got %0d want %0d", isol_rise, en1_last + 2); end
    checks++; if (done_rise !== isol_rise) begin errors++; $display("FAIL cont_done_with_isol got %0d want %0d", done_rise, isol_rise); end
    checks++; if (accepted !== 14) begin errors++; $display("FAIL cont_words_taken got %0d want 14", accepted); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL cont_done_state busy=%b ready=%b want 0 0", busy, cfg_ready); end
  endtask

  task automatic test_straddle;
    bit to;
    b_feed_on = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_done === 1'b1) begin to = 1'b0; break; end
    end
    repeat (3) tick();
    b_feed_on = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL strad_timeout done never rose"); end
    checks++; if (b_en0_cnt !== 12) begin errors++; $display("FAIL strad_en0_count got %0d want 12", b_en0_cnt); end
    checks++; if (b_en1_cnt !== 10) begin errors++; $display("FAIL strad_en1_count got %0d want 10", b_en1_cnt); end
    checks++; if (m0 !== 12'hFF0) begin errors++; $display("FAIL strad_chain0 got %h want ff0", m0); end
    checks++; if (m1 !== 10'h3F0) begin errors++; $display("FAIL strad_chain1 got %h want 3f0", m1); end
    checks++; if (b_accepted !== 3) begin errors++; $display("FAIL strad_words_taken got %0d want 3", b_accepted); end
    checks++; if (b_ready_after !== 0) begin errors++; $display("FAIL strad_ready_after_last got %0d want 0", b_ready_after); end
    checks++; if (b_both !== 0 || b_isol !== 1'b1) begin errors++; $display("FAIL strad_end both=%0d isol=%b want 0 1", b_both, b_isol); end
  endtask

  task automatic test_stall;
    bit to;
    int m;
    // Six withheld handshakes at word 2: the first still drains the
    // buffered last bit of word 1, the other five leave the shifter empty.
    begin_load(2, 6);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout done never rose"); end
    checks++; if (en0_cnt !== 64) begin errors++; $display("FAIL stall_en0_count got %0d want 64", en0_cnt); end
    checks++; if ((en0_last - en0_first + 1) - en0_cnt !== 5) begin errors++; $display("FAIL stall_gap got %0d want 5", (en0_last - en0_first + 1) - en0_cnt); end
    checks++; if (en1_cnt !== 48) begin errors++; $display("FAIL stall_en1_count got %0d want 48", en1_cnt); end
    m = content_errs();
    checks++; if (m !== 0) begin errors++; $display("FAIL stall_contents wrong_bits=%0d want 0", m); end
  endtask

  task automatic test_abort;
    bit reached, to;
    int m;
    begin_load(-1, 0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (en0_cnt >= 30) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL abort_reach_bit30 got %0d want 30", en0_cnt); end
    abort = 1'b1;
    feed_on = 1'b0;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_busy_done got %b%b want 00", busy, done); end
    checks++; if (isol_n !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_isol_ready got %b%b want 00", isol_n, cfg_ready); end
    checks++; if (en !== 2'b00 || en0_cnt !== 30) begin errors++; $display("FAIL abort_shift got en=%b count=%0d want 00 30", en, en0_cnt); end
    tick();
    begin_load(-1, 0);
    wait_done(to);
    m = content_errs();
    checks++; if (to || en0_cnt !== 64 || en1_cnt !== 48) begin errors++; $display("FAIL abort_reload to=%b en0=%0d en1=%0d want 0 64 48", to, en0_cnt, en1_cnt); end
    checks++; if (m !== 0) begin errors++; $display("FAIL abort_reload_contents wrong_bits=%0d want 0", m); end
  endtask

  task automatic test_reset_midload;
    bit reached, to;
    int m;
    begin_load(-1, 0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (en1_cnt >= 10) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL mrst_reach_load1 got %0d want 10", en1_cnt); end
    rst_n = 1'b0;
    feed_on = 1'b0;
    tick();
    checks++; if ({cfg_ready, h0, h1, en, isol_n, busy, done} !== 8'b0) begin errors++; $display("FAIL mrst_outputs got %b want 00000000", {cfg_ready, h0, h1, en, isol_n, busy, done}); end
    rst_n = 1'b1;
    tick();
    begin_load(-1, 0);
    wait_done(to);
    m = content_errs();
    checks++; if (to || en0_cnt !== 64 || en1_cnt !== 48) begin errors++; $display("FAIL mrst_reload to=%b en0=%0d en1=%0d want 0 64 48", to, en0_cnt, en1_cnt); end
    checks++; if (m !== 0) begin errors++; $display("FAIL mrst_reload_contents wrong_bits=%0d want 0", m); end
  endtask

  task automatic test_back_to_back;
    bit reached, to;
    int m;
    begin_load(-1, 0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (en1_cnt >= 5) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL b2b_reach_load1 got %0d want 5", en1_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(to);
    m = content_errs();
    checks++; if (to || en0_cnt + en1_cnt !== 112) begin errors++; $display("FAIL b2b_total_shifts to=%b got %0d want 112", to, en0_cnt + en1_cnt); end
    checks++; if (m !== 0) begin errors++; $display("FAIL b2b_contents wrong_bits=%0d want 0", m); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || isol_n !== 1'b1) begin errors++; $display("FAIL b2b_abort_in_done got %b%b want 11", done, isol_n); end
    begin_load(-1, 0);
    checks++; if (done !== 1'b0 || isol_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got done=%b isol=%b busy=%b want 0 0 1", done, isol_n, busy); end
    wait_done(to);
    m = content_errs();
    checks++; if (to || en0_cnt !== 64 || en1_cnt !== 48 || m !== 0) begin errors++; $display("FAIL b2b_second_load to=%b en0=%0d en1=%0d bad=%0d want 0 64 48 0", to, en0_cnt, en1_cnt, m); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_continuous();
    test_straddle();
    test_stall();
    test_abort();
    test_reset_midload();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
